// File: rtl/cache_bank_requester_pkg.sv
// Shared widths, request FIFO depth and FSM encoding for the cache bank requester.
package cache_bank_requester_pkg;

    localparam int DATA_WIDTH               = 32;
    localparam int CACHE_BANK_ADDRESS_WIDTH = 8;
    localparam int REQ_FIFO_DEPTH           = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } req_state_t;

endpackage

// File: rtl/cache_bank_requester_req_fifo.sv
// Request FIFO of {write, addr, wdata}; pointers carry an extra wrap bit so
// full and empty are told apart by the pointer difference.
module cache_bank_requester_req_fifo
    import cache_bank_requester_pkg::*;
#(
    parameter int DAT   = DATA_WIDTH,
    parameter int ADR   = CACHE_BANK_ADDRESS_WIDTH,
    parameter int DEPTH = REQ_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           push_write,
    input  logic [ADR-1:0] push_addr,
    input  logic [DAT-1:0] push_wdata,
    input  logic           pop,
    output logic           head_write,
    output logic [ADR-1:0] head_addr,
    output logic [DAT-1:0] head_wdata,
    output logic           full,
    output logic           empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 1 + ADR + DAT;

    logic [EW-1:0] mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   count;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign {head_write, head_addr, head_wdata} = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Storage is not reset; an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= {push_write, push_addr, push_wdata};
    end

endmodule

// File: rtl/cache_bank_requester.sv
// Cache bank port requester: request FIFO, one-access-in-flight FSM, registered bank port.
// Optional WRITE_ACK_EN: writes return an ack response and add the rsp_is_write port.
module cache_bank_requester
    import cache_bank_requester_pkg::*;
#(
    parameter int DAT        = DATA_WIDTH,
    parameter int ADR        = CACHE_BANK_ADDRESS_WIDTH,
    parameter int FIFO_DEPTH = REQ_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [ADR-1:0] req_addr,
    input  logic [DAT-1:0] req_wdata,
    output logic [ADR-1:0] bank_addr,
    output logic [DAT-1:0] bank_wdata,
    output logic           bank_wen_n,
    input  logic [DAT-1:0] bank_rdata,
    input  logic           bank_written,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DAT-1:0] rsp_rdata,
    output logic           rsp_hit,
`ifdef WRITE_ACK_EN
    output logic           rsp_is_write,
`endif
    output logic           busy
);

    req_state_t     state;
    req_state_t     state_next;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic           head_write;
    logic [ADR-1:0] head_addr;
    logic [DAT-1:0] head_wdata;
    logic [ADR-1:0] addr_next;
    logic [DAT-1:0] wdata_next;
    logic           wen_n_next;
    logic [DAT-1:0] rdata_next;
    logic           hit_next;
`ifdef WRITE_ACK_EN
    logic           is_write_next;
`endif

    // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
    assign push      = req_valid && req_ready;
    assign req_ready = reset && (!full || pop);
    assign rsp_valid = (state == RESP);
    assign busy      = !empty || (state != IDLE);

    cache_bank_requester_req_fifo #(
        .DAT   (DAT),
        .ADR   (ADR),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_write (req_write),
        .push_addr  (req_addr),
        .push_wdata (req_wdata),
        .pop        (pop),
        .head_write (head_write),
        .head_addr  (head_addr),
        .head_wdata (head_wdata),
        .full       (full),
        .empty      (empty)
    );

    // In ISSUE the registered bank_wen_n still tells whether the access is a write.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        addr_next  = bank_addr;
        wdata_next = bank_wdata;
        wen_n_next = 1'b1;
        rdata_next = rsp_rdata;
        hit_next   = rsp_hit;
`ifdef WRITE_ACK_EN
        is_write_next = rsp_is_write;
`endif
        case (state)
            IDLE:  pop = !empty;
            ISSUE: begin
                if (!bank_wen_n) begin
`ifdef WRITE_ACK_EN
                    state_next    = RESP;
                    rdata_next    = '0;
                    hit_next      = 1'b1;
                    is_write_next = 1'b1;
`else
                    state_next    = IDLE;
`endif
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = RESP;
                rdata_next = bank_rdata;
                hit_next   = bank_written;
`ifdef WRITE_ACK_EN
                is_write_next = 1'b0;
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                    pop        = !empty;
                end
            end
            default: state_next = IDLE;
        endcase
        if (pop) begin
            state_next = ISSUE;
            addr_next  = head_addr;
            wdata_next = head_wdata;
            wen_n_next = !head_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bank_addr  <= '0;
            bank_wdata <= '0;
            bank_wen_n <= 1'b1;
            rsp_rdata  <= '0;
            rsp_hit    <= 1'b0;
`ifdef WRITE_ACK_EN
            rsp_is_write <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            bank_addr  <= addr_next;
            bank_wdata <= wdata_next;
            bank_wen_n <= wen_n_next;
            rsp_rdata  <= rdata_next;
            rsp_hit    <= hit_next;
`ifdef WRITE_ACK_EN
            rsp_is_write <= is_write_next;
`endif
        end
    end

endmodule
